ama_riscv_mem_arbiter: RTL
==========================

Name: ama_riscv_mem_arbiter

Overview:
Shares one single-port synchronous BRAM between three requesters:
- core DMEM port (P0)
- core IMEM fetch port (P1)
- external loader/debug port (P2, UART bootloader)

It sits between the core's imem/dmem interfaces and the unified memory. Non-granted core ports stall via gnt. A starvation guard and a bounded loader burst lock keep every port live.

Parameters:
AW, 14, word address width (matches core imem_addr/dmem_addr)
STARVE_LIMIT, 8, cycles a pending port may be refused before it is forced to top priority
BURST_MAX, 16, max consecutive loader beats under lock

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pN_req  in  1  request, N=0..2; held with payload until pN_gnt
pN_addr  in  AW  word address
pN_we  in  4  byte write enables; 0 = read
pN_wdata  in  32  write data
pN_gnt  out  1  request accepted this cycle (combinational from req + registered state)
pN_rdata  out  32  read data
pN_rvalid  out  1  read data valid, exactly 1 cycle after a granted read
p2_lock  in  1  loader requests to keep ownership for a burst
mem_en  out  1  BRAM enable
mem_addr  out  AW  BRAM address
mem_we  out  4  BRAM byte write enables
mem_wdata  out  32  BRAM write data
mem_rdata  in  32  BRAM read data, 1-cycle latency

Behaviour:
- At most one gnt per cycle. Granted port's addr/we/wdata are muxed to mem_*. mem_en = any gnt.
- Reset values: all gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, state=ARB, starve counters=0, burst counter=0.
- FSM state ARB: grant order P0 > P1 > P2.
  - Exception: any port whose starve counter == STARVE_LIMIT is top priority.
  - Tie among starved ports: lowest index wins.
- FSM state LOCK: only P2 may be granted; P0/P1 gnt=0.
- ARB -> LOCK: P2 granted with p2_lock=1; burst counter loads 1.
- LOCK -> LOCK: each P2 grant with p2_lock=1 increments the burst counter.
- LOCK -> ARB, on either of:
  - p2_lock=0 (that beat is still granted);
  - burst counter reaching BURST_MAX. After a BURST_MAX exit, P2 is lowest priority for exactly one ARB cycle, even if starved.
- Starve counter per port:
  - increments when req=1 and gnt=0;
  - clears on gnt or req=0;
  - saturates at STARVE_LIMIT.
- Read return:
  - Owner tag (2b) and read flag are registered on grant.
  - Next cycle: the owner's rdata=mem_rdata and rvalid=1.
  - Other ports' rdata hold their last value.
  - Writes (we!=0) produce no rvalid.
- Back-to-back grants to different ports are allowed every cycle; the return path uses only the registered tag.
- Granted write and a pending read return in the same cycle: both proceed independently.
- Request dropped before grant: the protocol forbids it; the arbiter treats req=0 as withdrawn and clears that port's starve counter.
- Reset mid-LOCK or mid-read: state returns to ARB and the pending rvalid is suppressed on the next cycle.

Optional Feature:
AMA_RISCV_MEM_ARB_PERF_EN.
- When defined: adds outputs perf_conflict_cnt[31:0] and perf_starve_cnt[31:0], both reset to 0 and wrapping on overflow.
  - conflict: +1 per cycle with ≥2 reqs.
  - starve: +1 per cycle any starve counter is saturated.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ama_riscv_mem_arb_pkg holds:
  - port-index constants ARB_P_DMEM=0, ARB_P_IMEM=1, ARB_P_LOAD=2;
  - state enum arb_state_t {ARB, LOCK};
  - a request payload struct (addr, we, wdata).
- Sub-module ama_riscv_arb_starve_cnt: one saturating counter per port, with inputs req, gnt and output starved; instantiated three times.

Test Plan:
- P0+P1 req same cycle, reads addr 0x10/0x20 -> P0 gnt cycle 0, P1 gnt cycle 1; p0_rvalid cycle 1, p1_rvalid cycle 2 with the matching mem contents.
- P0 held continuously, P2 read held -> P2 gnt on cycle STARVE_LIMIT (8), its counter clears; P0 regains the next cycle.
- P2 lock burst of 20 writes, P1 requesting -> after 16 P2 beats, P1 gnt; P2 resumes only after P1 (P2 lowest for one ARB cycle).
- P2 lock, deassert p2_lock on beat 3 -> beat 3 granted, state ARB next cycle, pending P0 granted.
- P1 write we=4'b0011 data 0xAABBCCDD to addr 5 -> mem_we=0011, no p1_rvalid; subsequent P0 read of addr 5 returns 0x????CCDD merged.
- rst asserted the cycle after a P0 read grant -> p0_rvalid stays 0, all gnt 0, state ARB; with AMA_RISCV_MEM_ARB_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   - Port index constants (DMEM, IMEM, loader)
//   - Arbiter state enum
//   - Request payload struct
//   - Lowest-set-bit helper used for fixed-priority picks
package ama_riscv_mem_arb_pkg;

  localparam int unsigned ARB_P_DMEM = 0;
  localparam int unsigned ARB_P_IMEM = 1;
  localparam int unsigned ARB_P_LOAD = 2;

  // Payload address is carried at full word width; the top truncates to AW.
  localparam int unsigned ARB_ADDR_W = 32;

  typedef enum logic {ARB, LOCK} arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [3:0]            we;
    logic [31:0]           wdata;
  } arb_req_t;

  // One-hot of the lowest set bit (lowest index wins).
  function automatic logic [2:0] arb_lowest(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/ama_riscv_arb_starve_cnt.sv
// Per-port starvation counter.
// Counts cycles a request is pending but refused, saturating at STARVE_LIMIT.
// Clears whenever the port is granted or drops its request.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   req, gnt - request and grant of the watched port
//   starved  - counter has saturated
module ama_riscv_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STARVE_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q == CW'(STARVE_LIMIT));

endmodule

// File: rtl/ama_riscv_mem_arbiter.sv
// Three-way arbiter in front of one single-port synchronous BRAM.
//   P0 = core DMEM, P1 = core IMEM fetch, P2 = loader/debug (UART bootloader).
// Fixed priority P0 > P1 > P2, overridden by per-port starvation guards.
// P2 may lock the memory for a burst of up to BURST_MAX beats.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   pN_req/addr/we/wdata          - requester N payload, held until pN_gnt
//   pN_gnt                        - accepted this cycle
//   pN_rdata/pN_rvalid            - read return, one cycle after a granted read
//   p2_lock                       - loader asks to keep ownership
//   mem_en/addr/we/wdata/rdata    - BRAM side, 1-cycle read latency
// Optional (macro AMA_RISCV_MEM_ARB_PERF_EN):
//   perf_conflict_cnt             - cycles with two or more requests
//   perf_starve_cnt               - cycles with any starve counter saturated
module ama_riscv_mem_arbiter
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 14,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_MAX    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic [3:0]    p0_we,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic [31:0]   p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic [3:0]    p1_we,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic [31:0]   p1_rdata,
  output logic          p1_rvalid,
  input  logic          p2_req,
  input  logic [AW-1:0] p2_addr,
  input  logic [3:0]    p2_we,
  input  logic [31:0]   p2_wdata,
  output logic          p2_gnt,
  output logic [31:0]   p2_rdata,
  output logic          p2_rvalid,
  input  logic          p2_lock,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef AMA_RISCV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_conflict_cnt,
  output logic [31:0]   perf_starve_cnt
`endif
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  logic [2:0] req, gnt, starved, starve_eff, rvalid;
  arb_req_t   pl [3];
  arb_req_t   sel_pl;
  logic [1:0] sel_idx;

  arb_state_t    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          p2_low_q, p2_low_d;
  logic [1:0]    tag_q;
  logic          rd_q;
  logic [31:0]   rdata_q [3];

  assign req = {p2_req, p1_req, p0_req};

  always_comb begin
    pl[ARB_P_DMEM] = '{addr: ARB_ADDR_W'(p0_addr), we: p0_we, wdata: p0_wdata};
    pl[ARB_P_IMEM] = '{addr: ARB_ADDR_W'(p1_addr), we: p1_we, wdata: p1_wdata};
    pl[ARB_P_LOAD] = '{addr: ARB_ADDR_W'(p2_addr), we: p2_we, wdata: p2_wdata};
  end

  ama_riscv_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_p0 (
    .clk(clk), .rst(rst), .req(req[0]), .gnt(gnt[0]), .starved(starved[0])
  );
  ama_riscv_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_p1 (
    .clk(clk), .rst(rst), .req(req[1]), .gnt(gnt[1]), .starved(starved[1])
  );
  ama_riscv_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_p2 (
    .clk(clk), .rst(rst), .req(req[2]), .gnt(gnt[2]), .starved(starved[2])
  );

  // Right after a full-length burst, the loader's starvation claim is ignored for one cycle.
  assign starve_eff = req & starved & {~p2_low_q, 2'b11};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      burst_q  <= '0;
      p2_low_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      p2_low_q <= p2_low_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    p2_low_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (gnt[ARB_P_LOAD] && p2_lock) begin
          state_d = LOCK;
          burst_d = BW'(1);
        end
      end
      LOCK: begin
        if (!req[ARB_P_LOAD]) begin
          // Loader withdrew: release the memory rather than block the core.
          state_d = ARB;
          burst_d = '0;
        end else if (gnt[ARB_P_LOAD]) begin
          if (!p2_lock) begin
            state_d = ARB;
            burst_d = '0;
          end else if (burst_q == BW'(BURST_MAX - 1)) begin
            state_d  = ARB;
            burst_d  = '0;
            p2_low_d = 1'b1;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grant outputs
  always_comb begin
    gnt = '0;
    if (!rst) begin
      unique case (state_q)
        ARB:     gnt = (|starve_eff) ? arb_lowest(starve_eff) : arb_lowest(req);
        LOCK:    gnt[ARB_P_LOAD] = req[ARB_P_LOAD];
        default: gnt = '0;
      endcase
    end
  end

  assign p0_gnt = gnt[ARB_P_DMEM];
  assign p1_gnt = gnt[ARB_P_IMEM];
  assign p2_gnt = gnt[ARB_P_LOAD];

  always_comb begin
    sel_idx = 2'd0;
    sel_pl  = pl[ARB_P_DMEM];
    unique case (gnt)
      3'b010: begin
        sel_idx = 2'd1;
        sel_pl  = pl[ARB_P_IMEM];
      end
      3'b100: begin
        sel_idx = 2'd2;
        sel_pl  = pl[ARB_P_LOAD];
      end
      default: begin
        sel_idx = 2'd0;
        sel_pl  = pl[ARB_P_DMEM];
      end
    endcase
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_pl.addr[ARB_ADDR_W-1:AW];

  assign mem_en    = |gnt;
  assign mem_addr  = sel_pl.addr[AW-1:0];
  assign mem_we    = mem_en ? sel_pl.we : 4'b0;
  assign mem_wdata = sel_pl.wdata;

  // Return path depends only on the registered owner tag, so grants can change every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= 2'd0;
      rd_q  <= 1'b0;
    end else begin
      rd_q <= mem_en && (sel_pl.we == 4'b0);
      if (mem_en) tag_q <= sel_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rvalid[i] = rd_q && (tag_q == 2'(i)) && !rst;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rdata_q[i] <= '0;
      end else if (rvalid[i]) begin
        rdata_q[i] <= mem_rdata;
      end
    end
  end

  assign p0_rvalid = rvalid[ARB_P_DMEM];
  assign p1_rvalid = rvalid[ARB_P_IMEM];
  assign p2_rvalid = rvalid[ARB_P_LOAD];
  assign p0_rdata  = rvalid[ARB_P_DMEM] ? mem_rdata : rdata_q[ARB_P_DMEM];
  assign p1_rdata  = rvalid[ARB_P_IMEM] ? mem_rdata : rdata_q[ARB_P_IMEM];
  assign p2_rdata  = rvalid[ARB_P_LOAD] ? mem_rdata : rdata_q[ARB_P_LOAD];

`ifdef AMA_RISCV_MEM_ARB_PERF_EN
  logic [31:0] conflict_q, starve_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      if ((req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2])) begin
        conflict_q <= conflict_q + 32'd1;
      end
      if (|starved) starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign perf_conflict_cnt = conflict_q;
  assign perf_starve_cnt   = starve_cnt_q;
`endif

endmodule
